// File: rtl/usart_rx_fifo.sv
// Show-ahead receive FIFO for the USART receiver: stores each frame with its
// frame-error, parity-error and data-overrun flags, and reports fill status.
module usart_rx_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4,
  parameter int THRESH = 2,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_frame_error,
  input  logic              i_parity_error,
  input  logic              i_mcu_read,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_frame_error_flag,
  output logic              o_parity_error_flag,
  output logic              o_data_overrun_flag,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full,
  output logic              o_thresh
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + 3;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovr_q, ovr_d;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [ENT_W-1:0] head;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign pop   = i_mcu_read && !empty;
  assign push  = i_rx_valid && (!full || pop);
  assign drop  = i_rx_valid && full && !pop;

  // Flush wins over everything; a write in the flush cycle vanishes silently.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovr_d    = ovr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {ovr_q, i_frame_error, i_parity_error, i_rx_data};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        ovr_d           = 1'b0;
      end
      if (drop) begin
        ovr_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
    end
  end

  // Head entry is presented combinationally and masked to zero when empty.
  assign head                = mem_q[rd_ptr_q];
  assign o_data              = empty ? '0 : head[DATA_W-1:0];
  assign o_parity_error_flag = !empty && head[DATA_W];
  assign o_frame_error_flag  = !empty && head[DATA_W+1];
  assign o_data_overrun_flag = !empty && head[DATA_W+2];
  assign o_data_valid        = !empty;
  assign o_level             = level_q;
  assign o_full              = full;
  assign o_thresh            = (level_q >= LVL_W'(THRESH));

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Bench for usart_rx_fifo: directed scenarios then random traffic, compared
// against a queue-based model of the FIFO contents and overrun state.
module tb_usart_rx_fifo;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 4;
  localparam int THRESH = 2;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              i_clk;
  logic              i_rst_n;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_valid;
  logic              i_frame_error;
  logic              i_parity_error;
  logic              i_mcu_read;
  logic              i_flush;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_frame_error_flag;
  logic              o_parity_error_flag;
  logic              o_data_overrun_flag;
  logic [LVL_W-1:0]  o_level;
  logic              o_full;
  logic              o_thresh;

  typedef struct {
    bit       dor;
    bit       fe;
    bit       pe;
    bit [8:0] data;
  } entry_t;

  entry_t model_q[$];
  bit     model_ovr;
  int     checks;
  int     failures;

  usart_rx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .THRESH(THRESH)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rx_data          (i_rx_data),
    .i_rx_valid         (i_rx_valid),
    .i_frame_error      (i_frame_error),
    .i_parity_error     (i_parity_error),
    .i_mcu_read         (i_mcu_read),
    .i_flush            (i_flush),
    .o_data             (o_data),
    .o_data_valid       (o_data_valid),
    .o_frame_error_flag (o_frame_error_flag),
    .o_parity_error_flag(o_parity_error_flag),
    .o_data_overrun_flag(o_data_overrun_flag),
    .o_level            (o_level),
    .o_full             (o_full),
    .o_thresh           (o_thresh)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model queue implies.
  task automatic check_all(input string step);
    logic [31:0] e_data;
    logic        e_fe, e_pe, e_dor;
    int          n;
    n = model_q.size();
    e_data = 0; e_fe = 0; e_pe = 0; e_dor = 0;
    if (n > 0) begin
      e_data = 32'(model_q[0].data);
      e_fe   = model_q[0].fe;
      e_pe   = model_q[0].pe;
      e_dor  = model_q[0].dor;
    end
    check_val({step, ":data"},   32'(o_data), e_data);
    check_val({step, ":valid"},  32'(o_data_valid), 32'(n > 0));
    check_val({step, ":fe"},     32'(o_frame_error_flag), 32'(e_fe));
    check_val({step, ":pe"},     32'(o_parity_error_flag), 32'(e_pe));
    check_val({step, ":dor"},    32'(o_data_overrun_flag), 32'(e_dor));
    check_val({step, ":level"},  32'(o_level), 32'(n));
    check_val({step, ":full"},   32'(o_full), 32'(n == DEPTH));
    check_val({step, ":thresh"}, 32'(o_thresh), 32'(n >= THRESH));
  endtask

  task automatic model_step(input bit rxv, input bit [8:0] d, input bit fe, input bit pe,
                            input bit rd, input bit fl);
    entry_t e;
    bit     popped;
    bit     was_full;
    if (fl) begin
      model_q.delete();
      model_ovr = 0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      popped   = rd && (model_q.size() > 0);
      if (popped) void'(model_q.pop_front());
      if (rxv) begin
        if (!was_full || popped) begin
          e.dor = model_ovr; e.fe = fe; e.pe = pe; e.data = d;
          model_q.push_back(e);
          model_ovr = 0;
        end else begin
          model_ovr = 1;
        end
      end
    end
  endtask

  // Drive one cycle of requests, let the edge happen, then check 1 time unit later.
  task automatic cycle(input string step, input bit rxv, input bit [8:0] d, input bit fe,
                       input bit pe, input bit rd, input bit fl);
    i_rx_valid     = rxv;
    i_rx_data      = d;
    i_frame_error  = fe;
    i_parity_error = pe;
    i_mcu_read     = rd;
    i_flush        = fl;
    @(posedge i_clk);
    model_step(rxv, d, fe, pe, rd, fl);
    #1;
    i_rx_valid = 0; i_mcu_read = 0; i_flush = 0;
    i_frame_error = 0; i_parity_error = 0; i_rx_data = '0;
    check_all(step);
  endtask

  task automatic wr(input string step, input bit [8:0] d);
    cycle(step, 1, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input string step);
    cycle(step, 0, 9'h0, 0, 0, 1, 0);
  endtask

  initial begin
    checks = 0; failures = 0; model_ovr = 0;
    i_rst_n = 0; i_rx_valid = 0; i_rx_data = '0; i_frame_error = 0;
    i_parity_error = 0; i_mcu_read = 0; i_flush = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    @(negedge i_clk);
    i_rst_n = 1;

    cycle("wr_1a5_fe", 1, 9'h1A5, 1, 0, 0, 0);
    rd("drain0");

    for (int i = 1; i <= 4; i++) wr("fill", 9'(i));
    wr("drop5", 9'h005);
    for (int i = 0; i < 4; i++) rd("pop_after_drop");
    wr("wr6_dor", 9'h006);
    rd("drain1");

    for (int i = 1; i <= 4; i++) wr("fill2", 9'(i + 8));
    cycle("full_wr_rd", 1, 9'h0AA, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) rd("pop_to_aa");
    rd("drain2");

    rd("empty_rd");
    cycle("empty_wr_rd", 1, 9'h055, 0, 1, 1, 0);
    rd("drain3");

    for (int i = 1; i <= 4; i++) wr("fill3", 9'(i + 16));
    wr("drop_pend", 9'h0FF);
    rd("pop_pend");
    cycle("flush_wr", 1, 9'h0EE, 1, 1, 0, 1);
    wr("wr11", 9'h011);
    rd("drain4");

    wr("pre_rst_a", 9'h0C1);
    wr("pre_rst_b", 9'h0C2);
    #3;
    i_rst_n = 0;
    model_q.delete();
    model_ovr = 0;
    #1;
    check_all("async_rst");
    @(negedge i_clk);
    i_rst_n = 1;
    wr("wr_f0", 9'h0F0);
    rd("drain5");

    for (int i = 0; i < 300; i++) begin
      cycle("rand",
            $urandom_range(0, 99) < 55,
            9'($urandom),
            1'($urandom),
            1'($urandom),
            $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
